// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-outstanding imem requester feeding the IF/ID register.
// Optional perf counters (fetch_count, stall_count) enabled by FETCH_PERF_COUNT_EN.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] outInstruction,
  output logic [63:0] outPC,
  output logic        out_valid
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_req_addr;
  logic [ILEN-1:0]   r_buf;
  logic              r_drop;
  logic              r_started;
  logic [ILEN-1:0]   r_out_instr;
  logic [XLEN-1:0]   r_out_pc;
  logic              r_out_valid;

  logic              w_req_fire;
  logic              w_load;
  logic [ILEN-1:0]   w_load_data;
  logic              w_capture;
  logic [XLEN-1:0]   w_pc_next;
  logic              w_drop_next;

  assign w_req_fire     = imem_req_valid & imem_req_ready;
  assign imem_addr      = r_pc;
  assign outInstruction = r_out_instr;
  assign outPC          = r_out_pc;
  assign out_valid      = r_out_valid;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_FETCH;
    else          r_state <= w_next_state;
  end

  // A response is always consumed in WAIT so at most one request is ever in flight.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: if (w_req_fire) w_next_state = S_WAIT;
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (branch_taken || r_drop || !stall) w_next_state = S_FETCH;
          else                                  w_next_state = S_HOLD;
        end
      end
      S_HOLD: if (branch_taken || !stall) w_next_state = S_FETCH;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    w_load         = 1'b0;
    w_load_data    = imem_resp_data;
    w_capture      = 1'b0;
    w_pc_next      = r_pc;
    w_drop_next    = r_drop;
    case (r_state)
      S_FETCH: imem_req_valid = r_started & ~stall & ~branch_taken;
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (branch_taken || r_drop) begin
            w_drop_next = 1'b0;
          end else if (stall) begin
            w_capture = 1'b1;
          end else begin
            w_load    = 1'b1;
            w_pc_next = r_req_addr + XLEN'(4);
          end
        end else if (branch_taken) begin
          w_drop_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (!branch_taken && !stall) begin
          w_load      = 1'b1;
          w_load_data = r_buf;
          w_pc_next   = r_req_addr + XLEN'(4);
        end
      end
      default: ;
    endcase
    if (branch_taken) w_pc_next = branch_target;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_buf      <= '0;
      r_drop     <= 1'b0;
      r_started  <= 1'b0;
    end else begin
      r_pc      <= w_pc_next;
      r_drop    <= w_drop_next;
      r_started <= 1'b1;
      if (w_req_fire) r_req_addr <= r_pc;
      if (w_capture)  r_buf      <= imem_resp_data;
    end
  end

  // IF/ID register: flush beats stall and load; an idle unstalled cycle inserts a bubble.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (!stall) begin
      r_out_valid <= w_load;
      if (w_load) begin
        r_out_instr <= w_load_data;
        r_out_pc    <= r_req_addr;
      end
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_load && !flush && !stall) r_fetch_count <= r_fetch_count + 32'd1;
      if (stall)                      r_stall_count <= r_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus a mid-WAIT reset sequence.
module tb_fetch_stage;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] outInstruction;
  logic [63:0] outPC;
  logic        out_valid;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int tests = 0;
  int failed = 0;

  fetch_stage #(.RESET_PC(64'h0)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .branch_taken(branch_taken),
    .branch_target(branch_target), .stall(stall), .flush(flush),
    .outInstruction(outInstruction), .outPC(outPC), .out_valid(out_valid)
`ifdef FETCH_PERF_COUNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic        ready;
    logic        rvld;
    logic [31:0] rdata;
    logic        br;
    logic [63:0] tgt;
    logic        stl;
    logic        fls;
    logic        e_rv;
    logic [63:0] e_addr;
    logic        e_ov;
    logic [31:0] e_oi;
    logic [63:0] e_op;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rd, logic br, logic [63:0] tg,
                              logic st, logic fl, logic erv, logic [63:0] ea, logic eov,
                              logic [31:0] eoi, logic [63:0] eop);
    vec_t v;
    v.ready = rdy; v.rvld = rv; v.rdata = rd; v.br = br; v.tgt = tg; v.stl = st; v.fls = fl;
    v.e_rv = erv; v.e_addr = ea; v.e_ov = eov; v.e_oi = eoi; v.e_op = eop;
    return v;
  endfunction

  task automatic check_out(string name, logic erv, logic [63:0] ea, logic eov,
                           logic [31:0] eoi, logic [63:0] eop);
    tests++;
    if (imem_req_valid !== erv || imem_addr !== ea || out_valid !== eov ||
        outInstruction !== eoi || outPC !== eop) begin
      failed++;
      $display("FAIL %s: got rv=%b addr=%h ov=%b instr=%h pc=%h, expected rv=%b addr=%h ov=%b instr=%h pc=%h",
               name, imem_req_valid, imem_addr, out_valid, outInstruction, outPC,
               erv, ea, eov, eoi, eop);
    end
  endtask

  task automatic drive(logic rdy, logic rv, logic [31:0] rd, logic br, logic [63:0] tg,
                       logic st, logic fl);
    imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = rd;
    branch_taken = br; branch_target = tg; stall = st; flush = fl;
  endtask

  initial begin
    //            rdy rv data          br tgt                    st fl | rv addr                   ov instr         pc
    vecs[0]  = mk(1, 0, 32'h0,        0, 64'h0,                 0, 0,  0, 64'h0,                 0, 32'h0,        64'h0);
    vecs[1]  = mk(1, 0, 32'h0,        0, 64'h0,                 0, 0,  1, 64'h0,                 0, 32'h0,        64'h0);
    vecs[2]  = mk(1, 1, 32'h8B020020, 0, 64'h0,                 0, 0,  0, 64'h0,                 0, 32'h0,        64'h0);
    vecs[3]  = mk(1, 0, 32'h0,        0, 64'h0,                 0, 0,  1, 64'h4,                 1, 32'h8B020020, 64'h0);
    vecs[4]  = mk(1, 1, 32'hB4000041, 0, 64'h0,                 1, 0,  0, 64'h4,                 0, 32'h8B020020, 64'h0);
    vecs[5]  = mk(1, 0, 32'h0,        0, 64'h0,                 1, 0,  0, 64'h4,                 0, 32'h8B020020, 64'h0);
    vecs[6]  = mk(1, 0, 32'h0,        0, 64'h0,                 1, 0,  0, 64'h4,                 0, 32'h8B020020, 64'h0);
    vecs[7]  = mk(1, 0, 32'h0,        0, 64'h0,                 0, 0,  0, 64'h4,                 0, 32'h8B020020, 64'h0);
    vecs[8]  = mk(0, 0, 32'h0,        0, 64'h0,                 0, 0,  1, 64'h8,                 1, 32'hB4000041, 64'h4);
    vecs[9]  = mk(1, 0, 32'h0,        0, 64'h0,                 0, 0,  1, 64'h8,                 0, 32'hB4000041, 64'h4);
    vecs[10] = mk(1, 0, 32'h0,        1, 64'h100,               0, 0,  0, 64'h8,                 0, 32'hB4000041, 64'h4);
    vecs[11] = mk(1, 1, 32'hDEADBEEF, 0, 64'h0,                 0, 0,  0, 64'h100,               0, 32'hB4000041, 64'h4);
    vecs[12] = mk(1, 0, 32'h0,        0, 64'h0,                 0, 0,  1, 64'h100,               0, 32'hB4000041, 64'h4);
    vecs[13] = mk(1, 1, 32'h11111111, 1, 64'h200,               0, 0,  0, 64'h100,               0, 32'hB4000041, 64'h4);
    vecs[14] = mk(1, 0, 32'h0,        0, 64'h0,                 0, 0,  1, 64'h200,               0, 32'hB4000041, 64'h4);
    vecs[15] = mk(1, 1, 32'h22222222, 0, 64'h0,                 0, 0,  0, 64'h200,               0, 32'hB4000041, 64'h4);
    vecs[16] = mk(1, 0, 32'h0,        0, 64'h0,                 1, 1,  0, 64'h204,               1, 32'h22222222, 64'h200);
    vecs[17] = mk(1, 0, 32'h0,        1, 64'hFFFFFFFFFFFFFFFC,  0, 0,  0, 64'h204,               0, 32'h22222222, 64'h200);
    vecs[18] = mk(1, 0, 32'h0,        0, 64'h0,                 0, 0,  1, 64'hFFFFFFFFFFFFFFFC,  0, 32'h22222222, 64'h200);
    vecs[19] = mk(1, 1, 32'h33333333, 0, 64'h0,                 0, 1,  0, 64'hFFFFFFFFFFFFFFFC,  0, 32'h22222222, 64'h200);
    vecs[20] = mk(0, 0, 32'h0,        0, 64'h0,                 0, 0,  1, 64'h0,                 0, 32'h22222222, 64'h200);
    vecs[21] = mk(1, 0, 32'h0,        0, 64'h0,                 0, 0,  1, 64'h0,                 0, 32'h22222222, 64'h200);
    vecs[22] = mk(1, 1, 32'h44444444, 0, 64'h0,                 1, 0,  0, 64'h0,                 0, 32'h22222222, 64'h200);
    vecs[23] = mk(1, 0, 32'h0,        1, 64'h40,                0, 0,  0, 64'h0,                 0, 32'h22222222, 64'h200);
    vecs[24] = mk(1, 0, 32'h0,        0, 64'h0,                 0, 0,  1, 64'h40,                0, 32'h22222222, 64'h200);
    vecs[25] = mk(1, 1, 32'h55555555, 0, 64'h0,                 0, 0,  0, 64'h40,                0, 32'h22222222, 64'h200);
    vecs[26] = mk(0, 0, 32'h0,        0, 64'h0,                 1, 0,  0, 64'h44,                1, 32'h55555555, 64'h40);
    vecs[27] = mk(0, 0, 32'h0,        0, 64'h0,                 0, 0,  1, 64'h44,                1, 32'h55555555, 64'h40);
    vecs[28] = mk(0, 0, 32'h0,        0, 64'h0,                 0, 0,  1, 64'h44,                0, 32'h55555555, 64'h40);

    #2 RESET_N = 1'b0;
    #1 check_out("reset", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0);

    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ready, vecs[i].rvld, vecs[i].rdata, vecs[i].br, vecs[i].tgt,
            vecs[i].stl, vecs[i].fls);
      #1 check_out($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_ov,
                   vecs[i].e_oi, vecs[i].e_op);
      @(negedge CLOCK);
    end

    // Reset pulsed while a request is outstanding; the late response must be ignored.
    drive(1, 0, 32'h0, 0, 64'h0, 0, 0);
    #1 check_out("req_before_reset", 1'b1, 64'h44, 1'b0, 32'h55555555, 64'h40);
    @(negedge CLOCK);
    drive(0, 0, 32'h0, 0, 64'h0, 0, 0);
    #2 RESET_N = 1'b0;
    #1 check_out("reset_mid_wait", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    drive(0, 1, 32'h66666666, 0, 64'h0, 0, 0);
    #1 check_out("late_resp", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0);
    @(negedge CLOCK);
    drive(1, 0, 32'h0, 0, 64'h0, 0, 0);
    #1 check_out("restart_req", 1'b1, 64'h0, 1'b0, 32'h0, 64'h0);
    @(negedge CLOCK);
    drive(0, 1, 32'h77777777, 0, 64'h0, 0, 0);
    #1 check_out("restart_wait", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0);
    @(negedge CLOCK);
    drive(0, 0, 32'h0, 0, 64'h0, 0, 0);
    #1 check_out("restart_load", 1'b1, 64'h4, 1'b1, 32'h77777777, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the address of the first fetch after reset.
REQ-002 CLOCK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RESET_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req_valid  output  1  SHALL flag a valid instruction-memory read request.
REQ-005 imem_req_ready  input  1  SHALL flag that memory accepts the request this cycle.
REQ-006 imem_addr  output  64  SHALL be the request address (current PC).
REQ-007 imem_resp_valid  input  1  SHALL flag that returned data is valid this cycle.
REQ-008 imem_resp_data  input  32  SHALL carry the returned instruction word.
REQ-009 branch_taken  input  1  SHALL request a PC redirect.
REQ-010 branch_target  input  64  SHALL be the redirect address, sampled when branch_taken=1.
REQ-011 stall  input  1  SHALL hold the IF/ID register and block new requests.
REQ-012 flush  input  1  SHALL invalidate the IF/ID register.
REQ-013 outInstruction  output  32  SHALL drive the registered instruction to the sign-extend and decode stage.
REQ-014 outPC  output  64  SHALL be the address of outInstruction.
REQ-015 out_valid  output  1  SHALL flag that outInstruction/outPC are valid.

Function
REQ-016 FSM SHALL have states FETCH, WAIT, HOLD.
REQ-017 FETCH: imem_req_valid=1, imem_addr=PC; on imem_req_ready=1, SHALL go to WAIT and latch the request address.
REQ-018 At most one request SHALL be outstanding.
REQ-019 WAIT: on imem_resp_valid=1 with stall=0, SHALL load outInstruction/outPC/out_valid=1 on that edge, set PC=latched address+4, go to FETCH.
REQ-020 WAIT: on imem_resp_valid=1 with stall=1, SHALL capture the word in an internal buffer and go to HOLD; out_valid and outInstruction unchanged.
REQ-021 HOLD: on stall=0, SHALL move the buffered word to the IF/ID register, set PC=address+4, go to FETCH.
REQ-022 Load-to-use latency: response edge to out_valid=1 SHALL be 1 cycle when not stalled.
REQ-023 In FETCH, stall=1 SHALL force imem_req_valid=0.
REQ-024 branch_taken=1 SHALL set PC=branch_target on the next edge, in any state.
REQ-025 branch_taken=1 in WAIT SHALL set a drop flag; the pending response SHALL be discarded, then FSM goes to FETCH at the new PC.
REQ-026 branch_taken=1 in HOLD SHALL discard the buffered word and go to FETCH.
REQ-027 branch_taken=1 and imem_resp_valid=1 in the same WAIT cycle SHALL discard the response.
REQ-028 flush=1 SHALL clear out_valid on the next edge; flush has priority over stall and over a simultaneous load.
REQ-029 stall=1 and flush=0 SHALL hold outInstruction, outPC, out_valid unchanged.
REQ-030 PC arithmetic SHALL be 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
REQ-031 branch_target SHALL be used unmodified; alignment is not checked.

Reset
REQ-032 RESET_N=0 SHALL immediately set PC=RESET_PC, FSM=FETCH, drop flag=0, out_valid=0, outInstruction=0, outPC=0, imem_req_valid=0.
REQ-033 imem_req_valid SHALL rise no earlier than the first CLOCK edge after RESET_N deasserts.
REQ-034 A response arriving after reset for a pre-reset request SHALL be ignored.

Configuration
REQ-035 With FETCH_PERF_COUNT_EN defined, output fetch_count (32) SHALL increment on each IF/ID load with out_valid set, and stall_count (32) on each cycle with stall=1; both reset to 0 and wrap at 2^32.
REQ-036 Without FETCH_PERF_COUNT_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-037 Reset, RESET_PC=0, ready=1, response 1 cycle after accept with 32'h8B020020 -> out_valid=1, outPC=0, outInstruction=32'h8B020020; next imem_addr=4.
REQ-038 stall=1 held 3 cycles while response 32'hB4000041 arrives -> IF/ID holds prior word; word appears the cycle after stall drops.
REQ-039 branch_taken=1, target 64'h100, during WAIT -> pending response discarded; next imem_addr=64'h100.
REQ-040 flush=1 with stall=1 -> out_valid=0 next edge.
REQ-041 PC=64'hFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=0.
REQ-042 RESET_N pulsed low mid-WAIT -> outputs zero immediately; late response ignored; fetch restarts at RESET_PC.
